bcd_gray_arbiter: RTL and testbench
===================================

// Module: bcd_gray_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer for one shared BCD-to-Gray conversion datapath.
//   Two requesters each present a digit through a valid/ready handshake.
//   Each cycle the block grants at most one requester, converts its digit and
//   registers the Gray result in a single output slot, tagged with the source index.
//   The block sits between digit producers and any downstream Gray-code consumer.
// PARAMETERS
//   WIDTH       4   digit width in bits; minimum 2
//   PRIO_RESET  0   requester (0/1) that wins the first tie after reset
// PORTS
//   clk         in   1      single clock; all state updates on the rising edge
//   rst         in   1      synchronous, active-high reset
//   req0_valid  in   1      requester 0 holds a digit
//   req0_data   in   WIDTH  requester 0 BCD digit
//   req0_ready  out  1      requester 0 digit accepted this cycle
//   req1_valid  in   1      requester 1 holds a digit
//   req1_data   in   WIDTH  requester 1 BCD digit
//   req1_ready  out  1      requester 1 digit accepted this cycle
//   out_valid   out  1      output slot holds a result
//   out_data    out  WIDTH  Gray-coded result
//   out_src     out  1      index of the requester that produced out_data
//   out_err     out  1      digit was not valid BCD; 0 when BCD_CHECK_EN is undefined
//   out_ready   in   1      downstream consumes the result
// BEHAVIOUR
//   - Reset (synchronous, active-high)
//     - out_valid=0, out_data=0, out_src=0, out_err=0.
//     - last_grant=~PRIO_RESET.
//     - A result held in the slot when reset is asserted is discarded, not delivered.
//   - Slot FSM has two states, EMPTY and FULL.
//     - EMPTY->FULL: a grant is issued.
//     - FULL->EMPTY: out_ready=1 and no new grant is issued.
//     - FULL->FULL: out_ready=1 and a grant is issued (back-to-back, 1 result/cycle).
//     - FULL stall: out_ready=0 holds out_* stable and asserts no reqN_ready.
//   - can_load = ~out_valid | out_ready.
//   - Arbitration when can_load=1
//     - Only one requester valid: that requester is granted.
//     - Both valid: the requester != last_grant is granted.
//     - last_grant updates only on a grant.
//     - reqN_ready=1 exactly for the granted requester; at most one ready per cycle.
//   - Handshake rules
//     - Transfer occurs when reqN_valid & reqN_ready.
//     - A requester keeps valid and data stable until its transfer.
//     - Requesters do not wait for ready before asserting valid.
//     - reqN_ready is combinational from the valids, out_valid and out_ready.
//   - Conversion (combinational, MSB kept)
//     - g[WIDTH-1] = b[WIDTH-1].
//     - g[i] = b[i+1]^b[i] for i < WIDTH-1.
//   - Timing
//     - Latency is 1 cycle: the digit accepted in cycle N appears on out_data in cycle N+1.
//     - Sustained throughput is 1 result per cycle with out_ready held at 1.
//   - Boundary conditions
//     - No valid: no grant, and the slot drains if out_ready=1.
//     - Simultaneous drain and load: new data replaces old in the same edge; no bubble.
// CONFIGURATION
//   BCD_CHECK_EN defined
//     - out_err is registered with the result and set when the accepted digit
//       (low 4 bits) > 9.
//     - The value is still converted and delivered.
//   BCD_CHECK_EN undefined
//     - out_err is constant 0 and no compare logic exists.
// STRUCTURE
//   - Package bcd_gray_pkg
//     - Slot-state typedef {EMPTY, FULL}.
//     - BCD_MAX=9.
//     - Function bin2gray(WIDTH).
//   - Sub-module gray_conv_core: combinational WIDTH-bit binary-to-Gray converter,
//     instantiated once and driven by the grant multiplexer.
// TESTING
//   1. Reset: assert rst 2 cycles with req0_valid=1 -> out_valid=0, no ready;
//      first grant goes to PRIO_RESET.
//   2. Single: req0 data=4'b0011, out_ready=1 -> req0_ready in cycle N;
//      cycle N+1 out_data=4'b0010, out_src=0.
//   3. Fairness: both valid continuously (0->4'd5, 1->4'd9), out_ready=1
//      -> grants alternate 0,1,0,1; results 4'b0111 and 4'b1101 alternate.
//   4. Backpressure: out_ready=0 for 3 cycles while slot FULL
//      -> out_* frozen, req*_ready=0; release gives a back-to-back load on the release edge.
//   5. Mid-op reset: slot FULL with 4'b0010, rst pulsed
//      -> out_valid=0 next cycle; the discarded result never appears.
//   6. BCD_CHECK_EN: digit 4'd12 -> out_data=4'b1010, out_err=1;
//      without the macro out_err=0.

Source files
------------

// File: rtl/bcd_gray_arbiter_pkg.sv
// Shared types and helpers for the two-requester BCD-to-Gray arbiter.
package bcd_gray_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  localparam int unsigned BCD_MAX = 9;

  // Binary-to-Gray over the low `width` bits; the MSB passes through unchanged.
  function automatic logic [31:0] bin2gray(input logic [31:0] b, input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (b ^ (b >> 1)) & mask;
  endfunction

endpackage

// File: rtl/bcd_gray_arbiter_if.sv
// Request, response and result signals between digit producers, the arbiter and the consumer.
interface bcd_gray_arbiter_if #(
  parameter int unsigned WIDTH = 4
);

  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_err;
  logic             out_ready;

  // Environment side: producers and the downstream consumer.
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_src, out_err
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_src, out_err
  );

endinterface

// File: rtl/bcd_gray_arbiter_gray_conv_core.sv
// Combinational WIDTH-bit binary-to-Gray converter shared by both requesters.
module gray_conv_core
  import bcd_gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = WIDTH'(bin2gray(32'(bin), WIDTH));

endmodule

// File: rtl/bcd_gray_arbiter.sv
// Round-robin arbiter feeding one shared BCD-to-Gray converter into a single result slot.
// Define BCD_CHECK_EN to register an invalid-BCD flag alongside each result.
module bcd_gray_arbiter
  import bcd_gray_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter bit          PRIO_RESET = 1'b0
) (
  input logic               clk,
  input logic               rst,
  bcd_gray_arbiter_if.slave bus
);

  slot_state_e      state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] data_q;
  logic             src_q;
  logic             can_load;
  logic             gnt0, gnt1, any_grant;
  logic [WIDTH-1:0] conv_in, conv_out;

  assign can_load = (state_q == EMPTY) | bus.out_ready;

  // Grants are held off during reset so nothing is accepted and then dropped.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && can_load) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = last_grant_q;
        gnt1 = ~last_grant_q;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  assign any_grant = gnt0 | gnt1;
  assign conv_in   = gnt1 ? bus.req1_data : bus.req0_data;

  gray_conv_core #(
    .WIDTH(WIDTH)
  ) u_conv (
    .bin  (conv_in),
    .gray (conv_out)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    if (any_grant) begin
      last_grant_d = gnt1;
    end
    unique case (state_q)
      EMPTY: begin
        if (any_grant) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (any_grant) begin
          state_d = FULL;
        end else if (bus.out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      last_grant_q <= ~PRIO_RESET;
      data_q       <= '0;
      src_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      if (any_grant) begin
        data_q <= conv_out;
        src_q  <= gnt1;
      end
    end
  end

`ifdef BCD_CHECK_EN
  logic err_q;
  logic err_d;

  // Digits narrower than 4 bits can never exceed 9.
  if (WIDTH >= 4) begin : g_bcd_chk
    assign err_d = (conv_in[3:0] > 4'(BCD_MAX));
  end else begin : g_bcd_nochk
    assign err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (any_grant) begin
      err_q <= err_d;
    end
  end

  assign bus.out_err = err_q;
`else
  assign bus.out_err = 1'b0;
`endif

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.out_valid  = (state_q == FULL);
  assign bus.out_data   = data_q;
  assign bus.out_src    = src_q;

endmodule

// File: tb/tb_bcd_gray_arbiter.sv
// Directed self-checking bench for bcd_gray_arbiter (WIDTH=4, PRIO_RESET=0).
module tb_bcd_gray_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  bcd_gray_arbiter_if #(.WIDTH(4)) bus ();

  bcd_gray_arbiter #(
    .WIDTH      (4),
    .PRIO_RESET (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic exp_err12;

  initial begin
    n_checks = 0;
    n_fail   = 0;
`ifdef BCD_CHECK_EN
    exp_err12 = 1'b1;
`else
    exp_err12 = 1'b0;
`endif

    // Reset held for two cycles with requester 0 valid.
    rst            = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 4'd3;
    bus.req1_valid = 1'b0;
    bus.req1_data  = 4'd0;
    bus.out_ready  = 1'b1;
    tick();
    check("rst_ready0_c1", 32'(bus.req0_ready), 32'd0);
    check("rst_valid_c1", 32'(bus.out_valid), 32'd0);
    tick();
    check("rst_ready0_c2", 32'(bus.req0_ready), 32'd0);
    check("rst_valid_c2", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_src", 32'(bus.out_src), 32'd0);
    check("rst_err", 32'(bus.out_err), 32'd0);

    // First tie after reset goes to requester 0.
    rst            = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 4'd9;
    #1;
    check("tie_ready0", 32'(bus.req0_ready), 32'd1);
    check("tie_ready1", 32'(bus.req1_ready), 32'd0);
    tick();
    check("single_valid", 32'(bus.out_valid), 32'd1);
    check("single_data", 32'(bus.out_data), 32'b0010);
    check("single_src", 32'(bus.out_src), 32'd0);
    bus.req0_valid = 1'b0;
    #1;
    check("r1_ready1", 32'(bus.req1_ready), 32'd1);
    tick();
    check("r1_data", 32'(bus.out_data), 32'b1101);
    check("r1_src", 32'(bus.out_src), 32'd1);
    check("r1_err9", 32'(bus.out_err), 32'd0);
    bus.req1_valid = 1'b0;
    #1;
    check("idle_ready0", 32'(bus.req0_ready), 32'd0);
    check("idle_ready1", 32'(bus.req1_ready), 32'd0);
    tick();
    check("drain_valid", 32'(bus.out_valid), 32'd0);

    // Fairness: both valid continuously; last grant was 1, so 0 goes first.
    bus.req0_valid = 1'b1;
    bus.req0_data  = 4'd5;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 4'd9;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("fair_ready0_%0d", i), 32'(bus.req0_ready), 32'(i % 2 == 0));
      check($sformatf("fair_ready1_%0d", i), 32'(bus.req1_ready), 32'(i % 2 == 1));
      tick();
      check($sformatf("fair_valid_%0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("fair_data_%0d", i), 32'(bus.out_data),
            (i % 2 == 0) ? 32'b0111 : 32'b1101);
      check($sformatf("fair_src_%0d", i), 32'(bus.out_src), 32'(i % 2 == 1));
    end

    // Backpressure: slot holds 1101/src1 while both requesters wait.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_ready0_%0d", i), 32'(bus.req0_ready), 32'd0);
      check($sformatf("bp_ready1_%0d", i), 32'(bus.req1_ready), 32'd0);
      tick();
      check($sformatf("bp_valid_%0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp_data_%0d", i), 32'(bus.out_data), 32'b1101);
      check($sformatf("bp_src_%0d", i), 32'(bus.out_src), 32'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("rel_ready0", 32'(bus.req0_ready), 32'd1);
    check("rel_ready1", 32'(bus.req1_ready), 32'd0);
    tick();
    check("rel_valid", 32'(bus.out_valid), 32'd1);
    check("rel_data", 32'(bus.out_data), 32'b0111);
    check("rel_src", 32'(bus.out_src), 32'd0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    check("rel_drain", 32'(bus.out_valid), 32'd0);

    // Mid-op reset discards a pending 0010 result.
    bus.req0_valid = 1'b1;
    bus.req0_data  = 4'd3;
    tick();
    check("mid_full_data", 32'(bus.out_data), 32'b0010);
    bus.req0_valid = 1'b0;
    bus.out_ready  = 1'b0;
    rst            = 1'b1;
    tick();
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_data", 32'(bus.out_data), 32'd0);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("mid_post_valid", 32'(bus.out_valid), 32'd0);

    // Priority restored by reset: tie goes to requester 0 again.
    bus.req0_valid = 1'b1;
    bus.req0_data  = 4'd12;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 4'd1;
    #1;
    check("rst2_ready0", 32'(bus.req0_ready), 32'd1);
    check("rst2_ready1", 32'(bus.req1_ready), 32'd0);
    tick();
    check("bcd12_data", 32'(bus.out_data), 32'b1010);
    check("bcd12_err", 32'(bus.out_err), 32'(exp_err12));
    bus.req0_valid = 1'b0;
    tick();
    check("bcd1_data", 32'(bus.out_data), 32'b0001);
    check("bcd1_src", 32'(bus.out_src), 32'd1);
    check("bcd1_err", 32'(bus.out_err), 32'd0);
    bus.req1_valid = 1'b0;
    tick();
    check("final_drain", 32'(bus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
